// File: rtl/cmp_seq_pkg.sv
// Shared types and result mapping for the 32-bit branch-compare sequencer.
package cmp_seq_pkg;

    typedef enum logic [2:0] {
        CmpEq  = 3'd0,
        CmpNe  = 3'd1,
        CmpLt  = 3'd2,
        CmpGe  = 3'd3,
        CmpLtu = 3'd4,
        CmpGeu = 3'd5
    } cmp_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StHiAb,
        StHiBa,
        StLoAb,
        StLoBa,
        StDone
    } cmp_state_e;

    typedef enum logic [1:0] {
        RelLess,
        RelEqual,
        RelGreater
    } cmp_rel_e;

    function automatic logic is_signed_op(logic [2:0] op);
        return (op == CmpLt) || (op == CmpGe);
    endfunction

    function automatic logic cmp_result(logic [2:0] op, cmp_rel_e rel);
        case (op)
            CmpEq:          return rel == RelEqual;
            CmpNe:          return rel != RelEqual;
            CmpLt, CmpLtu:  return rel == RelLess;
            CmpGe, CmpGeu:  return rel != RelLess;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/prim_cmp_lt_16bit.sv
// 16-bit less-than primitive with selectable two's-complement interpretation.
module prim_cmp_lt_16bit (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_signed_en,
    output logic        o_lt
);

    always_comb begin
        if (i_signed_en) begin
            o_lt = $signed(i_a) < $signed(i_b);
        end else begin
            o_lt = i_a < i_b;
        end
    end

endmodule

// File: rtl/ctrl_cmp_seq_32bit.sv
// Evaluates 32-bit branch comparisons by sequencing one 16-bit less-than primitive
// over the high then low operand halves in both orders.
module ctrl_cmp_seq_32bit
    import cmp_seq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_result,
    output logic        o_lt,
    output logic        o_eq,
    output logic        o_illegal
);

    cmp_state_e  state_q;
    logic [2:0]  op_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;

    logic [15:0] cmp_a;
    logic [15:0] cmp_b;
    logic        cmp_signed;
    logic        cmp_lt;
    logic        decide;
    cmp_rel_e    rel;

    prim_cmp_lt_16bit u_cmp (
        .i_a         (cmp_a),
        .i_b         (cmp_b),
        .i_signed_en (cmp_signed),
        .o_lt        (cmp_lt)
    );

    assign o_ready = (state_q == StIdle);

    // Operand steering per phase; low halves are always unsigned magnitude.
    always_comb begin
        cmp_a      = 16'd0;
        cmp_b      = 16'd0;
        cmp_signed = 1'b0;
        decide     = 1'b0;
        rel        = RelEqual;
        case (state_q)
            StHiAb: begin
                cmp_a      = rs1_q[31:16];
                cmp_b      = rs2_q[31:16];
                cmp_signed = is_signed_op(op_q);
                decide     = cmp_lt;
                rel        = RelLess;
            end
            StHiBa: begin
                cmp_a      = rs2_q[31:16];
                cmp_b      = rs1_q[31:16];
                cmp_signed = is_signed_op(op_q);
                decide     = cmp_lt;
                rel        = RelGreater;
            end
            StLoAb: begin
                cmp_a  = rs1_q[15:0];
                cmp_b  = rs2_q[15:0];
                decide = cmp_lt;
                rel    = RelLess;
            end
            StLoBa: begin
                cmp_a  = rs2_q[15:0];
                cmp_b  = rs1_q[15:0];
                decide = 1'b1;
                rel    = cmp_lt ? RelGreater : RelEqual;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            op_q      <= 3'd0;
            rs1_q     <= 32'd0;
            rs2_q     <= 32'd0;
            o_valid   <= 1'b0;
            o_result  <= 1'b0;
            o_lt      <= 1'b0;
            o_eq      <= 1'b0;
            o_illegal <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        op_q    <= i_op;
                        rs1_q   <= i_rs1;
                        rs2_q   <= i_rs2;
                        state_q <= StHiAb;
                    end
                end
                StHiAb:  state_q <= decide ? StDone : StHiBa;
                StHiBa:  state_q <= decide ? StDone : StLoAb;
                StLoAb:  state_q <= decide ? StDone : StLoBa;
                StLoBa:  state_q <= StDone;
                StDone: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (decide) begin
                o_valid   <= 1'b1;
                o_lt      <= (rel == RelLess);
                o_eq      <= (rel == RelEqual);
                o_result  <= cmp_result(op_q, rel);
                o_illegal <= (op_q >= 3'd6);
            end
        end
    end

endmodule

// File: tb/tb_ctrl_cmp_seq_32bit.sv
// Self-checking bench for ctrl_cmp_seq_32bit: vector table plus scoreboard queue.
module tb_ctrl_cmp_seq_32bit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic        o_valid;
    logic        i_ready;
    logic        o_result;
    logic        o_lt;
    logic        o_eq;
    logic        o_illegal;

    ctrl_cmp_seq_32bit dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_op      (i_op),
        .i_rs1     (i_rs1),
        .i_rs2     (i_rs2),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_result  (o_result),
        .o_lt      (o_lt),
        .o_eq      (o_eq),
        .o_illegal (o_illegal)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic        res;
        logic        lt;
        logic        eq;
        logic        ill;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(logic [2:0] op, logic [31:0] a, logic [31:0] b, int lat,
                                logic res, logic lt, logic eq, logic ill);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.lat = lat;
        v.res = res; v.lt = lt; v.eq = eq; v.ill = ill;
        return v;
    endfunction

    // Reference model from whole-word arithmetic; latency from which half decides.
    function automatic vec_t model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        vec_t v;
        logic sg;
        logic lt;
        sg = (op == 3'd2) || (op == 3'd3);
        lt = sg ? ($signed(a) < $signed(b)) : (a < b);
        v.op = op; v.a = a; v.b = b;
        v.lt = lt;
        v.eq = (a == b);
        v.ill = (op >= 3'd6);
        if (a[31:16] != b[31:16]) v.lat = lt ? 2 : 3;
        else if (a != b)          v.lat = lt ? 4 : 5;
        else                      v.lat = 5;
        case (op)
            3'd0:       v.res = v.eq;
            3'd1:       v.res = ~v.eq;
            3'd2, 3'd4: v.res = lt;
            3'd3, 3'd5: v.res = ~lt;
            default:    v.res = 1'b0;
        endcase
        return v;
    endfunction

    task automatic wait_result(output int lat);
        lat = 1;
        while (!o_valid && lat < 12) begin
            @(posedge i_clk); #1;
            lat++;
        end
    endtask

    task automatic compare_result(input string tag, input int lat);
        vec_t e;
        e = sb.pop_front();
        check({tag, " valid"}, o_valid, 1);
        check({tag, " latency"}, lat, e.lat);
        check({tag, " result"}, o_result, e.res);
        check({tag, " lt"}, o_lt, e.lt);
        check({tag, " eq"}, o_eq, e.eq);
        check({tag, " illegal"}, o_illegal, e.ill);
    endtask

    task automatic issue(input vec_t v);
        @(negedge i_clk);
        check("ready before request", o_ready, 1);
        i_valid = 1'b1; i_op = v.op; i_rs1 = v.a; i_rs2 = v.b;
        sb.push_back(v);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_op = 3'($urandom); i_rs1 = $urandom; i_rs2 = $urandom;
        check("busy after accept", o_ready, 0);
    endtask

    task automatic run_req(input string tag, input vec_t v);
        int lat;
        issue(v);
        wait_result(lat);
        compare_result(tag, lat);
        @(posedge i_clk); #1;
        check({tag, " idle after consume"}, o_ready, 1);
        check({tag, " valid dropped"}, o_valid, 0);
    endtask

    initial begin
        int   lat;
        int   seen;
        logic [31:0] a;
        logic [31:0] b;

        vecs.push_back(mk(3'd2, 32'hFFFF_0000, 32'h0001_0000, 2, 1, 1, 0, 0));
        vecs.push_back(mk(3'd4, 32'hFFFF_0000, 32'h0001_0000, 3, 0, 0, 0, 0));
        vecs.push_back(mk(3'd5, 32'h1234_0005, 32'h1234_0007, 4, 0, 1, 0, 0));
        vecs.push_back(mk(3'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5, 1, 0, 1, 0));
        vecs.push_back(mk(3'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5, 0, 0, 1, 0));
        vecs.push_back(mk(3'd3, 32'h8000_0000, 32'h7FFF_FFFF, 2, 0, 1, 0, 0));
        vecs.push_back(mk(3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 3, 1, 0, 0, 0));
        vecs.push_back(mk(3'd2, 32'h0000_0009, 32'h0000_0003, 5, 0, 0, 0, 0));
        vecs.push_back(mk(3'd2, 32'h0000_8000, 32'h0000_0001, 5, 0, 0, 0, 0));
        vecs.push_back(mk(3'd6, 32'h0000_0005, 32'h0000_0005, 5, 0, 0, 1, 1));
        vecs.push_back(mk(3'd4, 32'h0000_FFFF, 32'h0001_0000, 2, 1, 1, 0, 0));

        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_op = 3'd0; i_rs1 = 32'd0; i_rs2 = 32'd0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("reset ready", o_ready, 1);
        check("reset valid", o_valid, 0);
        check("reset result", o_result, 0);
        check("reset lt", o_lt, 0);
        check("reset eq", o_eq, 0);
        check("reset illegal", o_illegal, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_req($sformatf("vec%0d", i), vecs[i]);
        end

        for (int k = 0; k < 8; k++) begin
            a = $urandom;
            b = (k % 2 == 1) ? {a[31:16], 16'($urandom)} : $urandom;
            if (k == 6) b = a;
            run_req($sformatf("rand%0d", k), model(3'($urandom_range(0, 7)), a, b));
        end

        // Backpressure with an illegal op: result must hold while inputs churn.
        i_ready = 1'b0;
        issue(mk(3'd7, 32'd1, 32'd2, 4, 0, 1, 0, 1));
        wait_result(lat);
        compare_result("backpressure", lat);
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            i_valid = 1'b1; i_op = 3'($urandom); i_rs1 = $urandom; i_rs2 = $urandom;
            @(posedge i_clk); #1;
            check("hold valid", o_valid, 1);
            check("hold illegal", o_illegal, 1);
            check("hold result", o_result, 0);
            check("hold lt", o_lt, 1);
            check("hold ready low", o_ready, 0);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        check("backpressure released", o_ready, 1);
        check("backpressure valid dropped", o_valid, 0);

        // Reset while the low halves are being compared.
        issue(mk(3'd0, 32'h5555_AAAA, 32'h5555_AAAA, 5, 1, 0, 1, 0));
        void'(sb.pop_front());
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        check("abort ready", o_ready, 1);
        check("abort valid", o_valid, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge i_clk); #1;
            if (o_valid) seen++;
        end
        check("no result after abort", seen, 0);
        check("idle after abort", o_ready, 1);
        run_req("after abort", model(3'd3, 32'h0000_0010, 32'hFFFF_FFF0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
